// File: rtl/mult_div_if.sv
// Operand/result bundle between execute stage and mult_div_unit.
// master drives requests and MTHI/MTLO, slave returns HI/LO status.
interface mult_div_if #(
  parameter int XLEN = 32
);
  logic            Start;
  logic [1:0]      Op;
  logic [XLEN-1:0] A;
  logic [XLEN-1:0] B;
  logic            HiWrite;
  logic            LoWrite;
  logic [XLEN-1:0] WriteData;
  logic            Busy;
  logic            Done;
  logic            DivZero;
  logic [XLEN-1:0] HI;
  logic [XLEN-1:0] LO;

  modport master (
    output Start, Op, A, B,
    output HiWrite, LoWrite, WriteData,
    input  Busy, Done, DivZero, HI, LO
  );

  modport slave (
    input  Start, Op, A, B,
    input  HiWrite, LoWrite, WriteData,
    output Busy, Done, DivZero, HI, LO
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// Fixed 33-cycle latency: 32 shift-add or restoring steps plus sign fixup.
module mult_div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input logic       CLK,
  input logic       RESET,
  mult_div_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIXUP
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CNT_W-1:0]  r_cnt;
  logic [1:0]        r_op;
  logic [XLEN-1:0]   r_b;
  logic [XLEN-1:0]   r_a_orig;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;
  logic [2*XLEN-1:0] r_acc;
  logic              r_neg_q;
  logic              r_neg_r;
  logic              r_busy;
  logic              r_done;
  logic              r_dz;

  logic              w_sgn_in;
  logic              w_sgn_op;
  logic              w_dz;
  logic [XLEN-1:0]   w_abs_a;
  logic [XLEN-1:0]   w_abs_b;
  logic [XLEN:0]     w_sum;
  logic [XLEN:0]     w_diff;
  logic [2*XLEN-1:0] w_acc_nxt;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_fix_hi;
  logic [XLEN-1:0]   w_fix_lo;

  assign w_sgn_in = ~bus.Op[0];
  assign w_abs_a  = (w_sgn_in && bus.A[XLEN-1]) ? -bus.A : bus.A;
  assign w_abs_b  = (w_sgn_in && bus.B[XLEN-1]) ? -bus.B : bus.B;

  // r_op[1] selects divide, r_op[0] selects unsigned
  assign w_sgn_op = ~r_op[0];
  assign w_dz     = r_op[1] && (r_b == '0);

  assign bus.Busy    = r_busy;
  assign bus.Done    = r_done;
  assign bus.DivZero = r_dz;
  assign bus.HI      = r_hi;
  assign bus.LO      = r_lo;

  always_comb begin
    w_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_b};
    w_diff = r_acc[2*XLEN-1:XLEN-1] - {1'b0, r_b};
    if (r_op[1]) begin
      // restoring step: remainder in upper half, quotient shifts in below
      w_acc_nxt = w_diff[XLEN]
                ? {r_acc[2*XLEN-2:0], 1'b0}
                : {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
    end else begin
      w_acc_nxt = r_acc[0]
                ? {w_sum, r_acc[XLEN-1:1]}
                : {1'b0, r_acc[2*XLEN-1:1]};
    end
  end

  always_comb begin
    w_prod = (w_sgn_op && r_neg_q) ? -r_acc : r_acc;
    w_quo  = (w_sgn_op && r_neg_q) ? -r_acc[XLEN-1:0]
                                   : r_acc[XLEN-1:0];
    w_rem  = (w_sgn_op && r_neg_r) ? -r_acc[2*XLEN-1:XLEN]
                                   : r_acc[2*XLEN-1:XLEN];
    if (!r_op[1]) begin
      w_fix_hi = w_prod[2*XLEN-1:XLEN];
      w_fix_lo = w_prod[XLEN-1:0];
    end else if (w_dz) begin
      w_fix_hi = r_a_orig;
      w_fix_lo = '1;
    end else begin
      w_fix_hi = w_rem;
      w_fix_lo = w_quo;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (bus.Start) w_state_nxt = CALC;
      CALC:    if (r_cnt == CNT_W'(XLEN-1)) w_state_nxt = FIXUP;
      FIXUP:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_b      <= '0;
      r_a_orig <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_acc    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dz     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.Start) begin
            r_op     <= bus.Op;
            r_acc    <= {{XLEN{1'b0}}, w_abs_a};
            r_b      <= w_abs_b;
            r_a_orig <= bus.A;
            r_neg_q  <= bus.A[XLEN-1] ^ bus.B[XLEN-1];
            r_neg_r  <= bus.A[XLEN-1];
            r_cnt    <= '0;
            r_busy   <= 1'b1;
          end else begin
            if (bus.HiWrite) r_hi <= bus.WriteData;
            if (bus.LoWrite) r_lo <= bus.WriteData;
          end
        end
        CALC: begin
          r_acc <= w_acc_nxt;
          r_cnt <= r_cnt + 1'b1;
        end
        FIXUP: begin
          r_hi   <= w_fix_hi;
          r_lo   <= w_fix_lo;
          r_dz   <= w_dz;
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: arithmetic reference model checked every
// cycle, plus directed vectors with literal expected results.
module tb_mult_div_unit;
  logic CLK   = 1'b0;
  logic RESET = 1'b0;

  mult_div_if #(.XLEN(32)) bus ();

  mult_div_unit #(.XLEN(32), .CNT_W(6)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int n_run  = 0;
  int n_fail = 0;

  logic        m_busy, m_done, m_dz;
  logic [31:0] m_hi, m_lo;
  logic [64:0] m_pend;
  int          m_left;

  function automatic logic [64:0] ref_op(
    input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int          sa, sb;
    longint      la, lb, q, r;
    logic [63:0] p;
    sa = a;
    sb = b;
    la = sa;
    lb = sb;
    case (op)
      2'd0: begin
        p = la * lb;
        return {1'b0, p};
      end
      2'd1: begin
        p = {32'h0, a} * {32'h0, b};
        return {1'b0, p};
      end
      2'd2: begin
        if (b == 32'h0) return {1'b1, a, 32'hFFFFFFFF};
        q = la / lb;
        r = la % lb;
        return {1'b0, r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'h0) return {1'b1, a, 32'hFFFFFFFF};
        la = longint'({32'h0, a});
        lb = longint'({32'h0, b});
        q = la / lb;
        r = la % lb;
        return {1'b0, r[31:0], q[31:0]};
      end
    endcase
  endfunction

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_dz   <= 1'b0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (m_left == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          {m_dz, m_hi, m_lo} <= m_pend;
        end else begin
          m_left <= m_left - 1;
        end
      end else if (bus.Start) begin
        m_pend <= ref_op(bus.Op, bus.A, bus.B);
        m_busy <= 1'b1;
        m_left <= 33;
      end else begin
        if (bus.HiWrite) m_hi <= bus.WriteData;
        if (bus.LoWrite) m_lo <= bus.WriteData;
      end
    end
  end

  task automatic chk(input string nm, input logic [71:0] got,
                     input logic [71:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic start_op(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b);
    bus.Start = 1'b1;
    bus.Op    = op;
    bus.A     = a;
    bus.B     = b;
    @(negedge CLK);
    bus.Start   = 1'b0;
    bus.HiWrite = 1'b0;
    bus.LoWrite = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge CLK);
      if (bus.Done === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run(input string nm, input logic [1:0] op,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] ehi, input logic [31:0] elo,
                     input logic edz);
    int lat;
    start_op(op, a, b);
    wait_done(lat);
    chk({nm, ".lat"}, 72'(lat), 72'(33));
    chk({nm, ".hi"}, 72'(bus.HI), 72'(ehi));
    chk({nm, ".lo"}, 72'(bus.LO), 72'(elo));
    chk({nm, ".dz"}, 72'(bus.DivZero), 72'(edz));
  endtask

  initial begin
    int lat;
    bus.Start     = 1'b0;
    bus.Op        = 2'd0;
    bus.A         = '0;
    bus.B         = '0;
    bus.HiWrite   = 1'b0;
    bus.LoWrite   = 1'b0;
    bus.WriteData = '0;

    repeat (3) @(negedge CLK);
    chk("reset", {5'b0, bus.Busy, bus.Done, bus.DivZero, bus.HI, bus.LO},
        72'h0);
    RESET = 1'b1;

    fork
      forever begin
        @(negedge CLK);
        chk("cycle",
            {5'b0, bus.Busy, bus.Done, bus.DivZero, bus.HI, bus.LO},
            {5'b0, m_busy, m_done, m_dz, m_hi, m_lo});
      end
    join_none

    @(negedge CLK);
    run("multu_max", 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF,
        32'hFFFFFFFE, 32'h00000001, 1'b0);
    run("mult_neg", 2'd0, 32'hFFFFFFFD, 32'd5,
        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
    run("mult_zero", 2'd0, 32'h0, 32'h12345678, 32'h0, 32'h0, 1'b0);
    run("div_neg", 2'd2, 32'hFFFFFFF9, 32'd2,
        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run("divu", 2'd3, 32'd13, 32'd10, 32'd3, 32'd1, 1'b0);
    run("div_ovf", 2'd2, 32'h80000000, 32'hFFFFFFFF,
        32'h0, 32'h80000000, 1'b0);
    run("divu_z", 2'd3, 32'h0000000D, 32'h0,
        32'h0000000D, 32'hFFFFFFFF, 1'b1);
    run("multu_clr", 2'd1, 32'd2, 32'd3, 32'h0, 32'd6, 1'b0);

    @(negedge CLK);
    bus.HiWrite   = 1'b1;
    bus.WriteData = 32'hA5A5A5A5;
    @(negedge CLK);
    bus.HiWrite = 1'b0;
    chk("mthi", 72'(bus.HI), 72'(32'hA5A5A5A5));

    start_op(2'd3, 32'd100, 32'd7);
    repeat (9) @(negedge CLK);
    bus.Start     = 1'b1;
    bus.Op        = 2'd0;
    bus.A         = 32'd5;
    bus.B         = 32'd5;
    bus.HiWrite   = 1'b1;
    bus.WriteData = 32'h5A5A5A5A;
    @(negedge CLK);
    bus.Start   = 1'b0;
    bus.HiWrite = 1'b0;
    chk("busy_mthi", 72'(bus.HI), 72'(32'hA5A5A5A5));
    chk("busy_flag", 72'(bus.Busy), 72'(1'b1));
    wait_done(lat);
    chk("ign.lat", 72'(lat), 72'(23));
    chk("ign.hi", 72'(bus.HI), 72'(32'd2));
    chk("ign.lo", 72'(bus.LO), 72'(32'd14));

    bus.HiWrite   = 1'b1;
    bus.WriteData = 32'hDEADBEEF;
    run("b2b", 2'd1, 32'd7, 32'd9, 32'h0, 32'd63, 1'b0);

    bus.LoWrite   = 1'b1;
    bus.WriteData = 32'h00001234;
    @(negedge CLK);
    bus.LoWrite = 1'b0;
    chk("mtlo_done", 72'(bus.LO), 72'(32'h00001234));

    start_op(2'd0, 32'd3, 32'd5);
    repeat (14) @(negedge CLK);
    @(posedge CLK);
    #2 RESET = 1'b0;
    #1 chk("mid_rst", {5'b0, bus.Busy, bus.Done, bus.DivZero, bus.HI, bus.LO},
           72'h0);
    @(negedge CLK);
    RESET = 1'b1;
    wait_done(lat);
    chk("no_done", 72'(lat), 72'(-1));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
